load_response_aligner: RTL

- Read-side counterpart of the store byte-enable path: turns raw 32-bit memory read words into architecturally correct load results (LB/LH/LW/LBU/LHU).
- Sits between the data-memory response port and the writeback stage.
- Captures per-load metadata (funct3, address offset) at request time in an in-order FIFO.
- Pairs each metadata entry with the in-order memory response, then extracts, sign- or zero-extends, and registers the result behind a valid/ready handshake.

---
 rtl/load_response_aligner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/load_response_aligner.sv
// Load response aligner: in-order metadata FIFO plus byte/halfword extract and extend.
// Optional performance counters are enabled by defining LOAD_PERF_CNT_EN.
module load_response_aligner #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_address_i,
    input  logic [2:0]      req_f3_i,
    input  logic            rsp_valid_i,
    output logic            rsp_ready_o,
    input  logic [XLEN-1:0] rsp_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_data_o,
    output logic            out_err_o
`ifdef LOAD_PERF_CNT_EN
    ,
    output logic [31:0]     perf_load_count_o,
    output logic [31:0]     perf_stall_count_o
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // Each entry is {funct3, address[1:0]}
    typedef logic [4:0] meta_t;

    meta_t           meta_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_err_q, out_err_d;

    logic            push, pop;
    meta_t           head;
    logic [2:0]      head_f3;
    logic [1:0]      head_off;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] fmt_data;
    logic            fmt_err;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^req_address_i[XLEN-1:2];

    assign req_ready_o = (count_q < CntW'(DEPTH));
    assign rsp_ready_o = (count_q != '0) && (!out_valid_q || out_ready_i);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = rsp_valid_i && rsp_ready_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            meta_q[wr_ptr_q] <= {req_f3_i, req_address_i[1:0]};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    assign head     = meta_q[rd_ptr_q];
    assign head_f3  = head[4:2];
    assign head_off = head[1:0];
    assign byte_sel = rsp_rdata_i[{head_off, 3'b000} +: 8];
    assign half_sel = rsp_rdata_i[{head_off[1], 4'b0000} +: 16];

    always_comb begin
        fmt_data = '0;
        fmt_err  = 1'b0;
        case (head_f3)
            3'b000: fmt_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: fmt_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001, 3'b101: begin
                if (head_off[0]) begin
                    fmt_err = 1'b1;
                end else begin
                    // Bit 2 of funct3 selects zero extension
                    fmt_data = {{(XLEN-16){half_sel[15] & ~head_f3[2]}}, half_sel};
                end
            end
            3'b010: begin
                if (head_off != 2'b00) begin
                    fmt_err = 1'b1;
                end else begin
                    fmt_data = rsp_rdata_i;
                end
            end
            default: fmt_err = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = fmt_data;
            out_err_d   = fmt_err;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_err_o   = out_err_q;

`ifdef LOAD_PERF_CNT_EN
    logic [31:0] perf_load_q, perf_load_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_load_d  = perf_load_q;
        perf_stall_d = perf_stall_q;
        if (out_valid_q && out_ready_i) begin
            perf_load_d = perf_load_q + 32'd1;
        end
        if (out_valid_q && !out_ready_i) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_load_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_load_q  <= perf_load_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_load_count_o  = perf_load_q;
    assign perf_stall_count_o = perf_stall_q;
`endif

endmodule
